iobuf_bank: RTL and testbench

Parametrised bank of bus-pin I/O controllers driving per-channel external level-translator buffers (direction and open-drain controls) and the matching FPGA tristate pin primitives. Each channel owns a direction state machine with break-before-make turnaround, so the FPGA pin and the buffer never drive against each other. Each channel also has a synchronised, glitch-filtered input path with edge pulses. Sits between protocol engines (SPI/I2C/UART cores) and the top-level pin instances; replaces per-pin hand-wired buffer instances.

---
 rtl/iobuf_bank.sv | 85 ++++++++
 tb/tb_iobuf_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iobuf_bank.sv
// iobuf_bank: per-pin direction control with break-before-make turnaround and filtered, edge-detected input.
module iobuf_bank #(
  parameter int CHANNELS    = 5,
  parameter int TURN_CYCLES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] oe_req,
  input  logic [CHANNELS-1:0] od_req,
  input  logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] bufdir,
  output logic [CHANNELS-1:0] bufod,
  output logic [CHANNELS-1:0] pin_oe,
  output logic [CHANNELS-1:0] pin_do,
  input  logic [CHANNELS-1:0] pin_di
);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [1:0] {IN, TO_OUT, OUT, TO_IN} state_t;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t state_q, state_d;
    logic [TW-1:0] tc_q, tc_d;
    logic [FW-1:0] fc_q, fc_d;
    logic s1_q, s2_q, din_q, din_d, rise_q, fall_q, busy_q, bufdir_q, bufod_q, bufod_d, pin_oe_q, pin_do_q;
    logic tc_end, fc_end;
    always_comb begin
      tc_end  = tc_q == TW'(TURN_CYCLES - 1);
      fc_end  = fc_q == FW'(FILTER_LEN - 1);
      state_d = state_q == IN     ? (oe_req[i] ? TO_OUT : IN) :
                state_q == TO_OUT ? (!oe_req[i] ? IN : tc_end ? OUT : TO_OUT) :
                state_q == OUT    ? (oe_req[i] ? OUT : TO_IN) :
                                    (oe_req[i] ? OUT : tc_end ? IN : TO_IN);
      tc_d    = (state_q == TO_OUT || state_q == TO_IN) && !tc_end ? tc_q + 1'b1 : '0;
      // Open-drain mode may only change while the buffer is not driving.
      bufod_d = state_q == IN ? od_req[i] : bufod_q;
      fc_d    = (s2_q == din_q || fc_end) ? '0 : fc_q + 1'b1;
      din_d   = (s2_q != din_q && fc_end) ? s2_q : din_q;
    end
    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IN;
        tc_q     <= '0;
        fc_q     <= '0;
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        din_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        busy_q   <= 1'b0;
        bufdir_q <= 1'b0;
        bufod_q  <= 1'b0;
        pin_oe_q <= 1'b0;
        pin_do_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        tc_q     <= tc_d;
        fc_q     <= fc_d;
        s1_q     <= pin_di[i];
        s2_q     <= s1_q;
        din_q    <= din_d;
        rise_q   <= din_d & ~din_q;
        fall_q   <= ~din_d & din_q;
        busy_q   <= state_d == TO_OUT || state_d == TO_IN;
        bufdir_q <= state_d != IN;
        bufod_q  <= bufod_d;
        pin_oe_q <= state_d == OUT;
        pin_do_q <= dout[i];
      end
    end
    assign din[i]    = din_q;
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
    assign busy[i]   = busy_q;
    assign bufdir[i] = bufdir_q;
    assign bufod[i]  = bufod_q;
    assign pin_oe[i] = pin_oe_q;
    assign pin_do[i] = pin_do_q;
  end
endmodule

// File: tb/tb_iobuf_bank.sv
// tb_iobuf_bank: directed vectors, corner sequences and a randomized run against a behavioural model.
module tb_iobuf_bank;
  localparam int C = 5, TC = 2, FL = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [C-1:0] oe_req = '0, od_req = '0, dout = '0, pin_di = '0;
  logic [C-1:0] din, rise, fall, busy, bufdir, bufod, pin_oe, pin_do;
  int checks = 0, failures = 0;

  iobuf_bank #(.CHANNELS(C), .TURN_CYCLES(TC), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .oe_req(oe_req), .od_req(od_req), .dout(dout),
    .din(din), .rise(rise), .fall(fall), .busy(busy), .bufdir(bufdir),
    .bufod(bufod), .pin_oe(pin_oe), .pin_do(pin_do), .pin_di(pin_di));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8*C-1:0] dut_vec();
    return {din, rise, fall, busy, bufdir, bufod, pin_oe, pin_do};
  endfunction

  // Behavioural model: guard countdown toward a target drive level, filter as a run-length count.
  logic [C-1:0] m_dir, m_oe, m_busy, m_od, m_do, m_s1, m_s2, m_din, m_rise, m_fall, m_tgt;
  int m_wait[C], m_run[C];

  task automatic m_reset();
    {m_dir, m_oe, m_busy, m_od, m_do, m_s1, m_s2, m_din, m_rise, m_fall, m_tgt} = '0;
    for (int c = 0; c < C; c++) begin m_wait[c] = 0; m_run[c] = 0; end
  endtask

  task automatic m_step(input logic [C-1:0] req, od, d, pdi);
    for (int c = 0; c < C; c++) begin
      m_od[c] = m_dir[c] ? m_od[c] : od[c];
      if (!m_dir[c]) begin
        if (req[c]) begin m_dir[c] = 1; m_busy[c] = 1; m_tgt[c] = 1; m_wait[c] = TC; end
      end else if (m_oe[c]) begin
        if (!req[c]) begin m_oe[c] = 0; m_busy[c] = 1; m_tgt[c] = 0; m_wait[c] = TC; end
      end else if (req[c] != m_tgt[c]) begin
        if (m_tgt[c]) m_dir[c] = 0; else m_oe[c] = 1;
        m_busy[c] = 0;
      end else begin
        m_wait[c]--;
        if (m_wait[c] == 0) begin
          if (m_tgt[c]) m_oe[c] = 1; else m_dir[c] = 0;
          m_busy[c] = 0;
        end
      end
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (m_s2[c] == m_din[c]) m_run[c] = 0;
      else if (m_run[c] + 1 == FL) begin
        m_din[c] = m_s2[c]; m_rise[c] = m_s2[c]; m_fall[c] = ~m_s2[c]; m_run[c] = 0;
      end else m_run[c]++;
      m_s2[c] = m_s1[c];
      m_s1[c] = pdi[c];
    end
    m_do = d;
  endtask

  typedef struct {logic oe, od, d, e_dir, e_oe, e_busy, e_od;} vec_t;
  vec_t tv[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1, 0, 1, 1, 0, 1, 0};
    tv[1]  = '{1, 0, 0, 1, 0, 1, 0};
    tv[2]  = '{1, 0, 1, 1, 1, 0, 0};
    tv[3]  = '{0, 0, 0, 1, 0, 1, 0};
    tv[4]  = '{0, 0, 1, 1, 0, 1, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{1, 0, 1, 1, 0, 1, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 0};
    tv[8]  = '{1, 1, 1, 1, 0, 1, 1};
    tv[9]  = '{1, 1, 0, 1, 0, 1, 1};
    tv[10] = '{1, 1, 1, 1, 1, 0, 1};
    tv[11] = '{0, 0, 0, 1, 0, 1, 1};
    tv[12] = '{1, 0, 1, 1, 1, 0, 1};
    tv[13] = '{0, 0, 0, 1, 0, 1, 1};
    tv[14] = '{0, 0, 1, 1, 0, 1, 1};
    tv[15] = '{0, 0, 0, 0, 0, 0, 1};
    tv[16] = '{0, 0, 1, 0, 0, 0, 0};

    // Reset with all pins high: outputs cleared, then din rises at the 4th edge after release.
    pin_di = '1;
    #12;
    chk("reset_outputs", 64'(dut_vec()), 64'(0));
    @(negedge clk) rst = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rst_din_e%0d", k), 64'(din), k >= 4 ? 64'('1 & {C{1'b1}}) : 64'(0));
      chk($sformatf("rst_rise_e%0d", k), 64'(rise), k == 4 ? 64'({C{1'b1}}) : 64'(0));
      chk($sformatf("rst_fall_e%0d", k), 64'(fall), 64'(0));
    end
    pin_di = '0;
    repeat (8) tick();

    // Direction, abort and open-drain vectors on channel 0.
    for (int k = 0; k < 17; k++) begin
      oe_req[0] = tv[k].oe; od_req[0] = tv[k].od; dout[0] = tv[k].d;
      tick();
      chk($sformatf("vec%0d_bufdir", k), 64'(bufdir[0]), 64'(tv[k].e_dir));
      chk($sformatf("vec%0d_pin_oe", k), 64'(pin_oe[0]), 64'(tv[k].e_oe));
      chk($sformatf("vec%0d_busy", k), 64'(busy[0]), 64'(tv[k].e_busy));
      chk($sformatf("vec%0d_bufod", k), 64'(bufod[0]), 64'(tv[k].e_od));
      chk($sformatf("vec%0d_pin_do", k), 64'(pin_do[0]), 64'(tv[k].d));
      chk($sformatf("vec%0d_others", k), 64'({bufdir[C-1:1], pin_oe[C-1:1], busy[C-1:1]}), 64'(0));
    end

    // One-cycle glitch on channel 2 is rejected.
    pin_di[2] = 1;
    tick();
    pin_di[2] = 0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("glitch_din_e%0d", k), 64'({din[2], rise[2], fall[2]}), 64'(0));
    end

    // Three-cycle pulse: din high for edges 4..6, one rise and one fall.
    pin_di[2] = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) pin_di[2] = 0;
      chk($sformatf("pulse_din_e%0d", k), 64'(din[2]), 64'(k >= 4 && k <= 6));
      chk($sformatf("pulse_rise_e%0d", k), 64'(rise[2]), 64'(k == 4));
      chk($sformatf("pulse_fall_e%0d", k), 64'(fall[2]), 64'(k == 7));
    end

    // Reset in the middle of a turn-on guard.
    oe_req[3] = 1;
    tick();
    tick();
    chk("midturn_busy", 64'({bufdir[3], pin_oe[3], busy[3]}), 64'(3'b101));
    rst = 1;
    #1;
    chk("midturn_reset", 64'(dut_vec()), 64'(0));
    {oe_req, od_req, dout, pin_di} = '0;
    m_reset();
    @(negedge clk) rst = 0;

    // Randomized run against the model, with the drive-contention invariant.
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 3) == 0) oe_req[c] = ~oe_req[c];
        if ($urandom_range(0, 2) == 0) pin_di[c] = ~pin_di[c];
      end
      od_req = C'($urandom);
      dout = C'($urandom);
      m_step(oe_req, od_req, dout, pin_di);
      tick();
      chk($sformatf("rand%0d_outputs", n), 64'(dut_vec()),
          64'({m_din, m_rise, m_fall, m_busy, m_dir, m_od, m_oe, m_do}));
      chk($sformatf("rand%0d_contention", n), 64'(pin_oe & ~bufdir), 64'(0));
      chk($sformatf("rand%0d_rise_fall", n), 64'(rise & fall), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
